wb_sram_pipe: RTL

Parametrised Wishbone B4 pipelined slave with on-chip storage. It is the next-generation successor of the fixed 8-bit, 4-entry scratch SRAM that sits behind the UART-to-Wishbone bridge. It adds configurable width and depth, byte selects, and configurable response latency. It also adds out-of-range error responses, clear-on-reset with stall, and cycle-abort handling. It connects directly to the bridge master port or to a future interconnect.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_resp_pipe.sv | 33 +++
 rtl/wb_sram_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone slave types: response pipeline entry, clear-sweep states and
// the bridge-wide byte-select width.
package wb_pkg;

    localparam int BUS_DATA_WIDTH  = 32;
    localparam int SEL_WIDTH       = BUS_DATA_WIDTH / 8;
    // Widest data word a response entry can carry; slaves zero-extend into it.
    localparam int RESP_DATA_WIDTH = 64;

    typedef struct packed {
        logic                       valid;
        logic                       err;
        logic                       we;
        logic [RESP_DATA_WIDTH-1:0] data;
    } resp_t;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

endpackage

// File: rtl/wb_resp_pipe.sv
// Purpose: fixed-length delay line carrying Wishbone responses in issue order.
// Latency: LATENCY cycles from resp_in to resp_out.
// Backpressure: none; flush or reset empties every stage on the same edge.
module wb_resp_pipe
    import wb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  flush,
    input  resp_t resp_in,
    output resp_t resp_out
);

    resp_t stage [LATENCY];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= resp_in;
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign resp_out = stage[LATENCY-1];

endmodule

// File: rtl/wb_sram_pipe.sv
// Purpose: Wishbone B4 pipelined slave over a byte-writable on-chip word array.
// Latency: ack/err LATENCY cycles after acceptance, strictly in order.
// Backpressure: stall_o only during the post-reset clear sweep; otherwise 1 req/cycle.
module wb_sram_pipe
    import wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 4,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    DEPTH          = 12,
    parameter int                    LATENCY        = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic                    we_i,
    output logic                    ack_o,
    output logic                    err_o,
    output logic                    rty_o,
    output logic                    stall_o,
    output logic [DATA_WIDTH-1:0]   dat_o
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t          state, state_nxt;
    logic [CW-1:0]   clr_adr, clr_adr_nxt;
    logic            clr_we;
    logic            acc;
    logic            in_range;
    logic [CW-1:0]   mem_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    resp_t           resp_in, resp_out;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_adr <= '0;
        end else begin
            state   <= state_nxt;
            clr_adr <= clr_adr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_adr_nxt = clr_adr;
        clr_we      = 1'b0;
        stall_o     = 1'b0;
        case (state)
            ST_CLEAR: begin
                stall_o = 1'b1;
                clr_we  = 1'b1;
                if (clr_adr == CW'(DEPTH - 1)) begin
                    state_nxt   = ST_RUN;
                    clr_adr_nxt = '0;
                end else begin
                    clr_adr_nxt = clr_adr + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign acc      = cyc_i & stb_i & ~stall_o & ~rst_i;
    assign in_range = ({1'b0, adr_i} < DEPTH_L);
    assign mem_idx  = CW'(adr_i);
    assign rd_word  = mem[mem_idx];

    // Reads see the array as it was before this edge; a write at the same edge
    // can only come from the same request, so there is no forwarding to do.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (clr_we) begin
                mem[clr_adr] <= INIT_VALUE;
            end else if (acc && in_range && we_i) begin
                for (int b = 0; b < SW; b++) begin
                    if (sel_i[b]) begin
                        mem[mem_idx][b*8 +: 8] <= dat_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        resp_in       = '0;
        resp_in.valid = acc;
        resp_in.err   = acc & ~in_range;
        resp_in.we    = we_i;
        if (acc && in_range && !we_i) begin
            resp_in.data = RESP_DATA_WIDTH'(rd_word);
        end
    end

    // Dropping cyc_i abandons the whole bus cycle, so every queued response goes.
    wb_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush    (~cyc_i),
        .resp_in  (resp_in),
        .resp_out (resp_out)
    );

    logic [DATA_WIDTH-1:0] resp_dat;
    assign resp_dat = DATA_WIDTH'(resp_out.data);

    assign ack_o = resp_out.valid & ~resp_out.err;
    assign err_o = resp_out.valid & resp_out.err;
    assign rty_o = 1'b0;
    assign dat_o = (ack_o && !resp_out.we) ? resp_dat : '0;

endmodule
